// File: rtl/ps2_command_sender_if.sv
// Command handshake between a host controller and ps2_command_sender.
// rx_byte/rx_valid exist only when PS2_TX_RESPONSE_EN is defined.
interface ps2_command_sender_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       busy;
  logic       cmd_done;
  logic       cmd_error;
`ifdef PS2_TX_RESPONSE_EN
  logic [7:0] rx_byte;
  logic       rx_valid;

  modport master (
    output cmd_data, cmd_valid, rx_byte, rx_valid,
    input  cmd_ready, busy, cmd_done, cmd_error
  );
  modport slave (
    input  cmd_data, cmd_valid, rx_byte, rx_valid,
    output cmd_ready, busy, cmd_done, cmd_error
  );
`else
  modport master (
    output cmd_data, cmd_valid,
    input  cmd_ready, busy, cmd_done, cmd_error
  );
  modport slave (
    input  cmd_data, cmd_valid,
    output cmd_ready, busy, cmd_done, cmd_error
  );
`endif
endinterface

// File: rtl/ps2_command_sender.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends one command byte and reports the line ACK.
// Optional macro PS2_TX_RESPONSE_EN adds a RESP state that waits for the device's 0xFA reply.
module ps2_command_sender #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic                clock,
  input  logic                reset,
  ps2_command_sender_if.slave bus,
  inout  wire                 PS2_CLK,
  inout  wire                 PS2_DAT
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
`ifdef PS2_TX_RESPONSE_EN
  localparam logic [2:0] ST_RESP      = 3'd6;
  localparam logic [7:0] RESP_ACK     = 8'hFA;
`endif

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INHIBIT_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [8:0]       shift_reg;
  logic [3:0]       bit_cnt;
  logic             clk_low;
  logic             dat_low;
  logic             done_q;
  logic             error_q;

  logic [1:0]       clk_sync;
  logic [1:0]       dat_sync;
  logic             clk_prev;
  logic             fall;
  logic             bus_idle;
  logic             bus_phase;
  logic             timeout_hit;

  // Open-drain pins: only ever pulled low or released.
  assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

  // NOTE: synchronizers reset to 1 (idle bus) so no false falling edge is seen after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DAT};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall     = clk_prev & ~clk_sync[1];
  assign bus_idle = clk_sync[1] & dat_sync[1];

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    bus_phase = 1'b0;
    case (state)
      ST_REQ, ST_SHIFT, ST_ACK, ST_WAIT_IDLE: bus_phase = 1'b1;
`ifdef PS2_TX_RESPONSE_EN
      ST_RESP:                                bus_phase = 1'b1;
`endif
      default:                                bus_phase = 1'b0;
    endcase
  end

  assign timeout_hit = bus_phase && (cnt == TIMEOUT_LAST);

  // One counter serves both the inhibit interval and the response timeout.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state == ST_INHIBIT && cnt == INHIBIT_LAST) begin
      cnt <= '0;
    end else if (state == ST_INHIBIT || bus_phase) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      clk_low   <= 1'b0;
      dat_low   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;

      if (timeout_hit) begin
        state   <= ST_IDLE;
        clk_low <= 1'b0;
        dat_low <= 1'b0;
        error_q <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.cmd_valid) begin
              shift_reg <= {~^bus.cmd_data, bus.cmd_data};
              bit_cnt   <= '0;
              clk_low   <= 1'b1;
              state     <= ST_INHIBIT;
            end
          end

          ST_INHIBIT: begin
            // Start bit goes low during the final inhibit cycle.
            if (cnt == INHIBIT_PRE) begin
              dat_low <= 1'b1;
            end
            if (cnt == INHIBIT_LAST) begin
              clk_low <= 1'b0;
              state   <= ST_REQ;
            end
          end

          ST_REQ: begin
            state <= ST_SHIFT;
          end

          ST_SHIFT: begin
            if (fall) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd9) begin
                dat_low <= 1'b0;
                state   <= ST_ACK;
              end else begin
                dat_low   <= ~shift_reg[0];
                shift_reg <= {1'b0, shift_reg[8:1]};
              end
            end
          end

          ST_ACK: begin
            if (fall) begin
              if (!dat_sync[1]) begin
                state <= ST_WAIT_IDLE;
              end else begin
                error_q <= 1'b1;
                state   <= ST_IDLE;
              end
            end
          end

          ST_WAIT_IDLE: begin
            if (bus_idle) begin
`ifdef PS2_TX_RESPONSE_EN
              state <= ST_RESP;
`else
              done_q <= 1'b1;
              state  <= ST_IDLE;
`endif
            end
          end

`ifdef PS2_TX_RESPONSE_EN
          ST_RESP: begin
            if (bus.rx_valid) begin
              state <= ST_IDLE;
              if (bus.rx_byte == RESP_ACK) begin
                done_q <= 1'b1;
              end else begin
                error_q <= 1'b1;
              end
            end
          end
`endif

          default: begin
            state   <= ST_IDLE;
            clk_low <= 1'b0;
            dat_low <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.cmd_done  = done_q;
  assign bus.cmd_error = error_q;

endmodule
